periphery_apb: RTL and testbench

PERIPHERY_APB -- requirements
Module: periphery_apb

---
 rtl/periphery_apb.sv | 227 ++++++++++++++++++++++
 tb/tb_periphery_apb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/periphery_apb.sv
// APB peripheral cluster: EF_TCC32-style timers followed by simple RTCs, each
// occupying one 256-byte slot above PERIPH_BA. Zero-wait-state APB slave.
module periphery_apb #(
    parameter int                APB_AW       = 32,
    parameter int                APB_DW       = 32,
    parameter logic [APB_AW-1:0] PERIPH_BA    = '0,
    parameter int                EF_TCC32_QTY = 1,
    parameter int                RTC_QTY      = 1
) (
    input  logic                    pclk,
    input  logic                    prst_n,
    input  logic [APB_AW-1:0]       paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [APB_DW-1:0]       pwdata,
    input  logic [APB_DW/8-1:0]     pstrb,
    output logic                    pready,
    output logic [APB_DW-1:0]       prdata,
    output logic                    pslverr,
    input  logic [EF_TCC32_QTY-1:0] ef_tcc32_ext_clk,
    output logic [EF_TCC32_QTY-1:0] ef_tcc32_irq,
    output logic [EF_TCC32_QTY-1:0] ef_tcc32_pwm,
    output logic [RTC_QTY-1:0]      rtc_irq
);
    localparam int SW = APB_AW - 8;

    // Handshake: a transfer is the access cycle psel&penable; pready is tied 1,
    // so every access completes (write commits, read data sampled) at that edge.
    logic [APB_AW-1:0] off;
    logic [SW-1:0]     slot;
    logic [7:0]        regoff;
    logic              in_range, wr_en, rd_en;
    logic [APB_DW-1:0] wmask, rdata_or;
    logic [EF_TCC32_QTY-1:0][APB_DW-1:0] t_rd;
    logic [RTC_QTY-1:0][APB_DW-1:0]      r_rd;

    assign off      = paddr - PERIPH_BA;
    assign slot     = off[APB_AW-1:8];
    assign regoff   = off[7:0];
    assign in_range = (paddr >= PERIPH_BA) && (slot < SW'(EF_TCC32_QTY + RTC_QTY));
    assign wr_en    = psel & penable & pwrite;
    assign rd_en    = psel & penable & ~pwrite;
    assign pready   = 1'b1;
    assign pslverr  = prst_n & psel & penable & ~in_range;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < APB_DW / 8; b++) wmask[8*b +: 8] = {8{pstrb[b]}};
    end

    function automatic logic [APB_DW-1:0] merge(input logic [APB_DW-1:0] old_v,
                                                input logic [APB_DW-1:0] new_v,
                                                input logic [APB_DW-1:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    for (genvar i = 0; i < EF_TCC32_QTY; i++) begin : g_tmr
        localparam logic [SW-1:0] ID = SW'(i);
        logic              sel, tick, ext_rise, to_evt, cmp_evt;
        logic [3:0]        ctrl_q, ctrl_d;
        logic [APB_DW-1:0] reload_q, reload_d, cmp_q, cmp_d, count_q, count_d, rmux;
        logic [1:0]        im_q, im_d, ris_q, ris_d, ris_clr;
        logic [2:0]        sync_q;
        logic              pwm_q, pwm_d;

        assign sel      = in_range && (slot == ID);
        assign ext_rise = sync_q[1] & ~sync_q[2];
        assign tick     = ctrl_q[0] & (ctrl_q[1] ? ext_rise : 1'b1);

        always_comb begin
            ctrl_d   = ctrl_q;
            reload_d = reload_q;
            cmp_d    = cmp_q;
            count_d  = count_q;
            im_d     = im_q;
            ris_clr  = '0;
            to_evt   = 1'b0;
            cmp_evt  = 1'b0;
            if (tick) begin
                if (count_q == reload_q) begin
                    count_d = '0;
                    to_evt  = 1'b1;
                    if (ctrl_q[3]) ctrl_d[0] = 1'b0;
                end else begin
                    count_d = count_q + 1'b1;
                end
                cmp_evt = (count_d == cmp_q);
            end
            // Register writes come last so they override same-cycle tick updates.
            if (wr_en && sel) begin
                case (regoff)
                    8'h00: if (pstrb[0]) ctrl_d = pwdata[3:0];
                    8'h04: reload_d = merge(reload_q, pwdata, wmask);
                    8'h08: cmp_d = merge(cmp_q, pwdata, wmask);
                    8'h0C: count_d = '0;
                    8'h10: if (pstrb[0]) im_d = pwdata[1:0];
                    8'h18: ris_clr = pwdata[1:0] & {2{pstrb[0]}};
                    default: ;
                endcase
            end
            ris_d = (ris_q & ~ris_clr) | {cmp_evt, to_evt};
            pwm_d = ctrl_d[0] & ctrl_d[2] & (count_d < cmp_d);
        end

        always_ff @(posedge pclk or negedge prst_n) begin
            if (!prst_n) begin
                ctrl_q   <= '0;
                reload_q <= '0;
                cmp_q    <= '0;
                count_q  <= '0;
                im_q     <= '0;
                ris_q    <= '0;
                sync_q   <= '0;
                pwm_q    <= 1'b0;
            end else begin
                ctrl_q   <= ctrl_d;
                reload_q <= reload_d;
                cmp_q    <= cmp_d;
                count_q  <= count_d;
                im_q     <= im_d;
                ris_q    <= ris_d;
                sync_q   <= {sync_q[1:0], ef_tcc32_ext_clk[i]};
                pwm_q    <= pwm_d;
            end
        end

        always_comb begin
            rmux = '0;
            case (regoff)
                8'h00: rmux = {{(APB_DW-4){1'b0}}, ctrl_q};
                8'h04: rmux = reload_q;
                8'h08: rmux = cmp_q;
                8'h0C: rmux = count_q;
                8'h10: rmux = {{(APB_DW-2){1'b0}}, im_q};
                8'h14: rmux = {{(APB_DW-2){1'b0}}, ris_q};
                default: rmux = '0;
            endcase
        end

        assign t_rd[i]         = (rd_en && sel) ? rmux : '0;
        assign ef_tcc32_irq[i] = |(ris_q & im_q);
        assign ef_tcc32_pwm[i] = pwm_q;
    end

    for (genvar i = 0; i < RTC_QTY; i++) begin : g_rtc
        localparam logic [SW-1:0] ID = SW'(EF_TCC32_QTY + i);
        logic              sel, tick, en_q, en_d, im_q, im_d, ris_q, ris_d, ris_clr;
        logic [APB_DW-1:0] presc_q, presc_d, sec_q, sec_d, alarm_q, alarm_d, pcnt_q, pcnt_d;
        logic [APB_DW-1:0] sec_inc, rmux;

        assign sel     = in_range && (slot == ID);
        assign tick    = en_q && (pcnt_q == presc_q);
        assign sec_inc = sec_q + 1'b1;

        always_comb begin
            en_d    = en_q;
            presc_d = presc_q;
            sec_d   = tick ? sec_inc : sec_q;
            alarm_d = alarm_q;
            im_d    = im_q;
            ris_clr = 1'b0;
            pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
            if (wr_en && sel) begin
                case (regoff)
                    8'h00: if (pstrb[0]) en_d = pwdata[0];
                    8'h04: begin
                        presc_d = merge(presc_q, pwdata, wmask);
                        pcnt_d  = '0;
                    end
                    8'h08: sec_d = merge(sec_q, pwdata, wmask);
                    8'h0C: alarm_d = merge(alarm_q, pwdata, wmask);
                    8'h10: if (pstrb[0]) im_d = pwdata[0];
                    8'h18: ris_clr = pwdata[0] & pstrb[0];
                    default: ;
                endcase
            end
            // The prescaler only runs while enabled and restarts from 0 on enable.
            if (!en_q || !en_d) pcnt_d = '0;
            ris_d = (ris_q & ~ris_clr) | (tick && (sec_inc == alarm_q));
        end

        always_ff @(posedge pclk or negedge prst_n) begin
            if (!prst_n) begin
                en_q    <= 1'b0;
                presc_q <= '0;
                sec_q   <= '0;
                alarm_q <= '0;
                im_q    <= 1'b0;
                ris_q   <= 1'b0;
                pcnt_q  <= '0;
            end else begin
                en_q    <= en_d;
                presc_q <= presc_d;
                sec_q   <= sec_d;
                alarm_q <= alarm_d;
                im_q    <= im_d;
                ris_q   <= ris_d;
                pcnt_q  <= pcnt_d;
            end
        end

        always_comb begin
            rmux = '0;
            case (regoff)
                8'h00: rmux = {{(APB_DW-1){1'b0}}, en_q};
                8'h04: rmux = presc_q;
                8'h08: rmux = sec_q;
                8'h0C: rmux = alarm_q;
                8'h10: rmux = {{(APB_DW-1){1'b0}}, im_q};
                8'h14: rmux = {{(APB_DW-1){1'b0}}, ris_q};
                default: rmux = '0;
            endcase
        end

        assign r_rd[i]    = (rd_en && sel) ? rmux : '0;
        assign rtc_irq[i] = ris_q & im_q;
    end

    always_comb begin
        rdata_or = '0;
        for (int t = 0; t < EF_TCC32_QTY; t++) rdata_or = rdata_or | t_rd[t];
        for (int r = 0; r < RTC_QTY; r++) rdata_or = rdata_or | r_rd[r];
    end

    assign prdata = prst_n ? rdata_or : '0;
endmodule

// File: tb/tb_periphery_apb.sv
// Directed bench for periphery_apb: APB driver pushes expected {pslverr, prdata}
// into a queue, a negedge monitor pops and compares on every access phase.
module tb_periphery_apb;
  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [0:0]  ef_tcc32_ext_clk = 1'b0;
  logic [0:0]  ef_tcc32_irq;
  logic [0:0]  ef_tcc32_pwm;
  logic [0:0]  rtc_irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];
  string       name_q[$];
  logic [32:0] mon_e;
  string       mon_nm;
  int          hi_cnt;

  periphery_apb dut (
    .pclk(pclk), .prst_n(prst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .ef_tcc32_ext_clk(ef_tcc32_ext_clk),
    .ef_tcc32_irq(ef_tcc32_irq), .ef_tcc32_pwm(ef_tcc32_pwm), .rtc_irq(rtc_irq)
  );

  // clock / watchdog
  always #5 pclk = ~pclk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: compares {pslverr, prdata} on each access phase
  always @(negedge pclk) begin
    if (prst_n && psel && penable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_access", 33'(paddr), 33'h1_FFFF_FFFF);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        check(mon_nm, {pslverr, prdata}, mon_e);
      end
    end
  end

  // driver tasks: each ends 1 time unit after a rising edge
  task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [32:0] e, input string nm);
    @(posedge pclk); #1;
    paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    apb_xfer(a, 1'b1, d, 4'hF, 33'h0, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input string nm);
    apb_xfer(a, 1'b0, 32'h0, 4'h0, {1'b0, d}, nm);
  endtask

  task automatic ext_pulse();
    ef_tcc32_ext_clk = 1'b1;
    repeat (4) @(posedge pclk);
    #1 ef_tcc32_ext_clk = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
  endtask

  initial begin
    // reset phase
    repeat (2) @(posedge pclk);
    #1;
    check("rst_pready", 33'(pready), 33'd1);
    check("rst_outputs", {29'b0, pslverr, ef_tcc32_irq, ef_tcc32_pwm, rtc_irq}, 33'd0);
    check("rst_prdata", 33'(prdata), 33'd0);
    prst_n = 1'b1;

    // all defined registers read 0 after reset
    for (int o = 0; o < 7; o++) begin
      rd(32'(o * 4), 32'h0, "rst_tmr_reg");
      rd(32'h100 + 32'(o * 4), 32'h0, "rst_rtc_reg");
    end
    check("rst_irq_pwm", {30'b0, ef_tcc32_irq, ef_tcc32_pwm, rtc_irq}, 33'd0);

    // register access, byte strobes, read-only RIS
    wr(32'h04, 32'hA5A5_A5A5, "wr_reload");
    rd(32'h04, 32'hA5A5_A5A5, "rd_reload");
    apb_xfer(32'h08, 1'b1, 32'hFFFF_FFFF, 4'b0001, 33'h0, "wr_cmp_strb");
    rd(32'h08, 32'h0000_00FF, "rd_cmp_strb");
    wr(32'h14, 32'h3, "wr_ris");
    rd(32'h14, 32'h0, "rd_ris_ro");

    // pclk-sourced count: each enable/disable pair of writes yields 3 ticks
    wr(32'h04, 32'd3, "wr_reload3");
    wr(32'h10, 32'd1, "wr_im");
    wr(32'h00, 32'd1, "wr_en");
    wr(32'h00, 32'd0, "wr_dis");
    rd(32'h0C, 32'd3, "count_after3");
    rd(32'h14, 32'd0, "ris_before_wrap");
    check("irq_before_wrap", 33'(ef_tcc32_irq), 33'd0);
    wr(32'h00, 32'd1, "wr_en2");
    wr(32'h00, 32'd0, "wr_dis2");
    rd(32'h0C, 32'd2, "count_after_wrap");
    rd(32'h14, 32'd1, "ris_to");
    check("irq_wrap", 33'(ef_tcc32_irq), 33'd1);
    wr(32'h18, 32'd1, "wr_icr");
    rd(32'h14, 32'd0, "ris_cleared");
    check("irq_cleared", 33'(ef_tcc32_irq), 33'd0);

    // externally clocked: exact sequence 0,1,2,3,0
    wr(32'h0C, 32'h1234, "wr_count_clr");
    rd(32'h0C, 32'd0, "count_seq0");
    wr(32'h00, 32'd3, "wr_en_ext");
    for (int k = 1; k <= 4; k++) begin
      ext_pulse();
      rd(32'h0C, 32'(k % 4), "count_seq");
    end
    rd(32'h14, 32'd1, "ris_ext_wrap");
    check("irq_ext_wrap", 33'(ef_tcc32_irq), 33'd1);
    wr(32'h18, 32'd1, "wr_icr_ext");
    check("irq_ext_cleared", 33'(ef_tcc32_irq), 33'd0);

    // PWM duty: RELOAD=9, CMP=3 -> high while COUNT in {0,1,2}
    wr(32'h00, 32'd0, "wr_stop");
    wr(32'h04, 32'd9, "wr_reload9");
    wr(32'h08, 32'd3, "wr_cmp3");
    wr(32'h0C, 32'd0, "wr_count0");
    wr(32'h00, 32'd5, "wr_pwm_en");
    hi_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (ef_tcc32_pwm[0]) hi_cnt++;
    end
    check("pwm_duty_6_of_20", 33'(hi_cnt), 33'd6);

    // one-shot: EN clears after a single period, other CTRL bits kept
    wr(32'h00, 32'd0, "wr_stop2");
    wr(32'h18, 32'd3, "wr_icr3");
    wr(32'h0C, 32'd0, "wr_count0b");
    wr(32'h00, 32'hD, "wr_oneshot");
    repeat (20) @(posedge pclk);
    #1;
    rd(32'h00, 32'hC, "oneshot_ctrl");
    rd(32'h0C, 32'd0, "oneshot_count");
    rd(32'h14, 32'd3, "oneshot_ris");
    check("oneshot_pwm", 33'(ef_tcc32_pwm), 33'd0);
    check("oneshot_irq", 33'(ef_tcc32_irq), 33'd1);
    wr(32'h18, 32'd3, "wr_icr_final");
    check("irq_final", 33'(ef_tcc32_irq), 33'd0);

    // RTC: PRESC=1 -> SEC steps every 2 cycles, alarm at 2
    wr(32'h104, 32'd1, "wr_presc");
    wr(32'h10C, 32'd2, "wr_alarm");
    wr(32'h110, 32'd1, "wr_rtc_im");
    wr(32'h100, 32'd1, "wr_rtc_en");
    check("rtc_irq_start", 33'(rtc_irq), 33'd0);
    rd(32'h108, 32'd1, "rtc_sec1");
    rd(32'h108, 32'd2, "rtc_sec2");
    check("rtc_irq_alarm", 33'(rtc_irq), 33'd1);
    wr(32'h100, 32'd0, "wr_rtc_dis");
    wr(32'h118, 32'd1, "wr_rtc_icr");
    check("rtc_irq_cleared", 33'(rtc_irq), 33'd0);

    // decode errors and undefined offsets
    apb_xfer(32'h200, 1'b1, 32'hFFFF_FFFF, 4'hF, {1'b1, 32'h0}, "wr_oob");
    apb_xfer(32'h200, 1'b0, 32'h0, 4'h0, {1'b1, 32'h0}, "rd_oob");
    apb_xfer(32'h1000, 1'b0, 32'h0, 4'h0, {1'b1, 32'h0}, "rd_far_oob");
    rd(32'h00, 32'hC, "oob_no_alias_ctrl");
    rd(32'h08, 32'd3, "oob_no_alias_cmp");
    rd(32'h10C, 32'd2, "oob_alarm_kept");
    wr(32'h1C, 32'hFFFF_FFFF, "wr_undef_off");
    rd(32'h1C, 32'h0, "rd_undef_off");

    // asynchronous reset while the timer is running
    wr(32'h00, 32'd5, "wr_run_before_rst");
    repeat (3) @(posedge pclk);
    #2 prst_n = 1'b0;
    #1;
    check("midrst_outputs", {29'b0, pslverr, ef_tcc32_irq, ef_tcc32_pwm, rtc_irq}, 33'd0);
    check("midrst_pready", 33'(pready), 33'd1);
    @(posedge pclk);
    #1 prst_n = 1'b1;
    rd(32'h00, 32'h0, "post_rst_ctrl");
    rd(32'h0C, 32'h0, "post_rst_count");
    rd(32'h10C, 32'h0, "post_rst_alarm");

    repeat (2) @(posedge pclk);
    #1;
    check("queue_drained", 33'(exp_q.size()), 33'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
